// File: rtl/request_queue.sv
// request_queue: bounded in-order request queue between the trace parser and the DRAM command scheduler.
// Latency: a push is visible at the head right after the capturing edge, and a pop exposes the next entry right after its edge.
// Backpressure: queue_full comes from the registered count. A non-NOP strobe while full is dropped and sets sticky overflow_err.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   op_ready_s            parser strobe, with opcode_in / address_in
//   queue_full            count == DEPTH; the parser must hold its op
//   head_valid            head entry valid
//   head_opcode           opcode of the oldest entry (NOP when empty)
//   head_address          address of the oldest entry (0 when empty)
//   head_age              age of the oldest entry (0 when empty)
//   pop                   scheduler consumes the head; ignored when empty
//   occupancy             number of valid entries
//   overflow_err          sticky; a non-NOP strobe arrived while full
//
// Build option: define REQ_QUEUE_DEBUG_EN to enable push/pop trace
// messages and an assertion on the rising edge of overflow_err.

typedef enum logic [1:0] {
  READ   = 2'd0,
  WRITE  = 2'd1,
  IFETCH = 2'd2,
  NOP    = 2'd3
} parsed_op_t;

module request_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 33,
  parameter int AGE_WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_ready_s,
  input  parsed_op_t                   opcode_in,
  input  logic [ADDRESS_WIDTH-1:0]     address_in,
  output logic                         queue_full,
  output logic                         head_valid,
  output parsed_op_t                   head_opcode,
  output logic [ADDRESS_WIDTH-1:0]     head_address,
  output logic [AGE_WIDTH-1:0]         head_age,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage. Left unreset on purpose: the head outputs are gated by
  // count, so stale contents are never visible.
  parsed_op_t               op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [AGE_WIDTH-1:0]     age_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;

  logic             push;
  logic             pop_eff;
  logic             overflow_hit;
  logic [DEPTH-1:0] entry_valid;

  // Flags come from the pre-edge count. A full queue therefore rejects a
  // strobe even when a pop in the same cycle would free a slot.
  assign queue_full   = (count == CNT_W'(DEPTH));
  assign head_valid   = (count != '0);
  assign occupancy    = count;

  assign push         = op_ready_s && (opcode_in != NOP) && !queue_full;
  assign pop_eff      = pop && head_valid;
  assign overflow_hit = op_ready_s && (opcode_in != NOP) && queue_full;

  always_comb begin
    next_count = count;
    if (push && !pop_eff) begin
      next_count = count + 1'b1;
    end else if (pop_eff && !push) begin
      next_count = count - 1'b1;
    end
  end

  // An entry is live when its distance from rd_ptr (mod DEPTH) is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign entry_valid[g] = (CNT_W'(PTR_W'(PTR_W'(g) - rd_ptr)) < count);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= next_count;
      if (overflow_hit) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // A newly written entry starts at age 0. Live entries age by one per cycle
  // and hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        op_mem[i]   <= opcode_in;
        addr_mem[i] <= address_in;
        age_mem[i]  <= '0;
      end else if (entry_valid[i] && (age_mem[i] != '1)) begin
        age_mem[i]  <= age_mem[i] + 1'b1;
      end
    end
  end

  always_comb begin
    head_opcode  = NOP;
    head_address = '0;
    head_age     = '0;
    if (head_valid) begin
      head_opcode  = op_mem[rd_ptr];
      head_address = addr_mem[rd_ptr];
      head_age     = age_mem[rd_ptr];
    end
  end

`ifdef REQ_QUEUE_DEBUG_EN
  logic [31:0] dbg_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_cycle <= '0;
    end else begin
      dbg_cycle <= dbg_cycle + 1'b1;
      if (push) begin
        $display("[request_queue] cycle %0d push %s addr 0x%0h occ %0d",
                 dbg_cycle, opcode_in.name(), address_in, next_count);
      end
      if (pop_eff) begin
        $display("[request_queue] cycle %0d pop  %s addr 0x%0h occ %0d",
                 dbg_cycle, head_opcode.name(), head_address, next_count);
      end
      assert (!(overflow_hit && !overflow_err))
        else $error("[request_queue] overflow: dropped address 0x%0h", address_in);
    end
  end
`endif

endmodule

// File: tb/tb_request_queue.sv
// tb_request_queue: directed self-checking bench for request_queue.
// Inputs are driven and outputs sampled on the falling edge; expected values are hand-derived constants.
// Ends with a single pass/total summary line.

module tb_request_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_ready_s = 1'b0;
  parsed_op_t  opcode_in = NOP;
  logic [32:0] address_in = '0;
  logic        pop = 1'b0;

  logic        queue_full;
  logic        head_valid;
  parsed_op_t  head_opcode;
  logic [32:0] head_address;
  logic [7:0]  head_age;
  logic [4:0]  occupancy;
  logic        overflow_err;

  int n_checks = 0;
  int n_pass   = 0;

  request_queue #(.DEPTH(16), .ADDRESS_WIDTH(33), .AGE_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_ready_s   (op_ready_s),
    .opcode_in    (opcode_in),
    .address_in   (address_in),
    .queue_full   (queue_full),
    .head_valid   (head_valid),
    .head_opcode  (head_opcode),
    .head_address (head_address),
    .head_age     (head_age),
    .pop          (pop),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_op(input parsed_op_t op, input logic [32:0] a);
    op_ready_s = 1'b1;
    opcode_in  = op;
    address_in = a;
    step();
    op_ready_s = 1'b0;
    opcode_in  = NOP;
  endtask

  function automatic parsed_op_t op_of(input int i);
    case (i % 3)
      0:       return READ;
      1:       return WRITE;
      default: return IFETCH;
    endcase
  endfunction

  task automatic check_reset_state(input string pfx);
    check({pfx, "_valid"},    64'(head_valid),   64'd0);
    check({pfx, "_opcode"},   64'(head_opcode),  64'(NOP));
    check({pfx, "_address"},  64'(head_address), 64'd0);
    check({pfx, "_age"},      64'(head_age),     64'd0);
    check({pfx, "_occ"},      64'(occupancy),    64'd0);
    check({pfx, "_full"},     64'(queue_full),   64'd0);
    check({pfx, "_overflow"}, 64'(overflow_err), 64'd0);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_reset_state("rst");

    // Single push, then aging
    push_op(READ, 33'h1_0000_0040);
    check("push1_valid", 64'(head_valid),   64'd1);
    check("push1_op",    64'(head_opcode),  64'(READ));
    check("push1_addr",  64'(head_address), 64'h1_0000_0040);
    check("push1_occ",   64'(occupancy),    64'd1);
    check("push1_age0",  64'(head_age),     64'd0);
    repeat (5) step();
    check("push1_age5",  64'(head_age),     64'd5);

    // Fill to full
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) push_op(op_of(i), 33'h100 + 33'(i));
    check("fill_occ",  64'(occupancy),    64'd16);
    check("fill_full", 64'(queue_full),   64'd1);
    check("fill_ovf",  64'(overflow_err), 64'd0);
    push_op(NOP, 33'h999);
    check("nop_full_ovf", 64'(overflow_err), 64'd0);
    push_op(WRITE, 33'h1234);
    check("ovf_set",  64'(overflow_err), 64'd1);
    check("ovf_occ",  64'(occupancy),    64'd16);
    check("ovf_head", 64'(head_address), 64'h100);
    check("ovf_op",   64'(head_opcode),  64'(READ));

    // Full + pop + strobe: the push is rejected and the pop proceeds
    op_ready_s = 1'b1;
    opcode_in  = WRITE;
    address_in = 33'h5555;
    pop        = 1'b1;
    check("fps_occ_pre", 64'(occupancy), 64'd16);
    step();
    op_ready_s = 1'b0;
    opcode_in  = NOP;
    pop        = 1'b0;
    check("fps_occ",  64'(occupancy),    64'd15);
    check("fps_head", 64'(head_address), 64'h101);
    check("fps_op",   64'(head_opcode),  64'(WRITE));
    check("fps_ovf",  64'(overflow_err), 64'd1);

    // Drain in order. The dropped addresses must never reach the head.
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 64'(head_address), 64'h100 + 64'(i));
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    check("drain_valid", 64'(head_valid), 64'd0);
    check("drain_occ",   64'(occupancy),  64'd0);
    check("drain_full",  64'(queue_full), 64'd0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("pop_empty_occ", 64'(occupancy), 64'd0);

    // Push and pop together on an empty queue: the pop is ignored
    op_ready_s = 1'b1;
    opcode_in  = READ;
    address_in = 33'h2000;
    pop        = 1'b1;
    step();
    check("ep_occ",  64'(occupancy),    64'd1);
    check("ep_head", 64'(head_address), 64'h2000);

    // Sustained one-in/one-out for 40 cycles, so the pointers wrap twice
    for (int k = 1; k <= 40; k++) begin
      opcode_in  = op_of(k);
      address_in = 33'h2000 + 33'(k);
      check($sformatf("il_head_%0d", k), 64'(head_address), 64'h2000 + 64'(k - 1));
      step();
      check($sformatf("il_occ_%0d", k), 64'(occupancy), 64'd1);
    end
    op_ready_s = 1'b0;
    opcode_in  = NOP;
    check("il_last", 64'(head_address), 64'h2028);
    step();
    pop = 1'b0;
    check("il_empty", 64'(occupancy), 64'd0);

    // Age saturation
    push_op(WRITE, 33'h3000);
    check("age_0", 64'(head_age), 64'd0);
    repeat (254) step();
    check("age_254", 64'(head_age), 64'd254);
    step();
    check("age_255", 64'(head_age), 64'd255);
    repeat (45) step();
    check("age_sat", 64'(head_age), 64'd255);
    pop = 1'b1;
    step();
    pop = 1'b0;

    // Reset mid-operation
    for (int i = 0; i < 7; i++) push_op(op_of(i), 33'h400 + 33'(i));
    check("pre_rst_occ", 64'(occupancy), 64'd7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_state("mid_rst");
    push_op(IFETCH, 33'h80);
    check("post_rst_valid", 64'(head_valid),   64'd1);
    check("post_rst_op",    64'(head_opcode),  64'(IFETCH));
    check("post_rst_addr",  64'(head_address), 64'h80);
    check("post_rst_occ",   64'(occupancy),    64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
